// File: rtl/dut_if.sv
// Bus bundle for the dut RAM: write port, read port, and init status.
// master drives requests (bench/host side); slave is the RAM itself.
interface dut_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
);
  logic [A_WIDTH-1:0] address_write;
  logic [D_WIDTH-1:0] data_write;
  logic               write_enable;
  logic [A_WIDTH-1:0] address_read;
  logic [D_WIDTH-1:0] data_read;
  logic               init_busy;

  modport master (
    output address_write,
    output data_write,
    output write_enable,
    output address_read,
    input  data_read,
    input  init_busy
  );

  modport slave (
    input  address_write,
    input  data_write,
    input  write_enable,
    input  address_read,
    output data_read,
    output init_busy
  );
endinterface

// File: rtl/dut.sv
// Dual-port (1W/1R) RAM with registered read and a post-reset clear sweep.
// Define DUT_BYPASS_EN to forward same-address write data onto the read port.
module dut #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic  clk,
  input  logic  rst_n,
  dut_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** A_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [D_WIDTH-1:0] data_read_q, data_read_d;
  logic [D_WIDTH-1:0] mem_q [DEPTH];

  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] rd_word;

`ifdef DUT_BYPASS_EN
  always_comb begin
    rd_word = mem_q[bus.address_read];
    if (bus.write_enable && (bus.address_write == bus.address_read)) begin
      rd_word = bus.data_write;
    end
  end
`else
  always_comb begin
    rd_word = mem_q[bus.address_read];
  end
`endif

  // The single write port is shared: the clear sweep owns it while initialising.
  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    data_read_d = data_read_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.address_write;
    mem_wdata   = bus.data_write;
    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = init_ptr_q;
        mem_wdata   = '0;
        data_read_d = '0;
        if (init_ptr_q == '1) begin
          state_d = ST_RUN;
        end else begin
          init_ptr_d = init_ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        mem_we      = bus.write_enable;
        data_read_d = rd_word;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      data_read_q <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      data_read_q <= data_read_d;
    end
  end

  // Storage is left untouched on reset edges; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_read = data_read_q;
  assign bus.init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_dut.sv
// Directed self-checking bench for dut: init sweep, read/write timing,
// dropped writes during init, collision behaviour and mid-init reset.
module tb_dut;

  localparam int D_WIDTH = 16;
  localparam int A_WIDTH = 5;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  dut_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) bus ();

  dut #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] exp);
    check(tag, 32'(bus.data_read), exp);
  endtask

  task automatic chk_busy(input string tag, input logic [31:0] exp);
    check(tag, 32'(bus.init_busy), exp);
  endtask

  initial begin
    n_asserts          = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.write_enable   = 1'b0;
    bus.address_write  = '0;
    bus.data_write     = '0;
    bus.address_read   = '0;

    // Two reset edges
    step();
    chk_busy("rst1_busy", 1);
    chk_rd("rst1_rd", 0);
    step();
    chk_busy("rst2_busy", 1);
    chk_rd("rst2_rd", 0);

    // Release; 32 sweep edges. Writes at edge 5 (addr 31) and edge 32 (addr 10) are dropped.
    rst_n            = 1'b1;
    bus.address_read = 5'd3;
    for (int e = 1; e <= 32; e++) begin
      bus.write_enable = 1'b0;
      if (e == 5) begin
        bus.write_enable  = 1'b1;
        bus.address_write = 5'd31;
        bus.data_write    = 16'h1234;
      end else if (e == 32) begin
        bus.write_enable  = 1'b1;
        bus.address_write = 5'd10;
        bus.data_write    = 16'hBEEF;
      end
      step();
      chk_busy("init_busy", (e < 32) ? 1 : 0);
      chk_rd("init_rd_zero", 0);
    end

    // First edge after completion accepts a write; also read addr 31
    bus.write_enable  = 1'b1;
    bus.address_write = 5'd9;
    bus.data_write    = 16'h5A5A;
    bus.address_read  = 5'd31;
    step();
    chk_rd("drop_init_write_31", 16'h0000);
    bus.write_enable = 1'b0;
    bus.address_read = 5'd9;
    step();
    chk_rd("first_write_after_init", 16'h5A5A);
    bus.address_read = 5'd10;
    step();
    chk_rd("drop_last_edge_write", 16'h0000);

    // Write 0xA5A5 to 3, read 3 then 4
    bus.write_enable  = 1'b1;
    bus.address_write = 5'd3;
    bus.data_write    = 16'hA5A5;
    step();
    bus.write_enable = 1'b0;
    bus.address_read = 5'd3;
    step();
    chk_rd("rd_addr3", 16'hA5A5);
    bus.address_read = 5'd4;
    step();
    chk_rd("rd_addr4", 16'h0000);

    // Same-address collision on addr 7
    bus.write_enable  = 1'b1;
    bus.address_write = 5'd7;
    bus.data_write    = 16'h1111;
    step();
    bus.data_write   = 16'h2222;
    bus.address_read = 5'd7;
    step();
`ifdef DUT_BYPASS_EN
    chk_rd("collide_bypass", 16'h2222);
`else
    chk_rd("collide_old", 16'h1111);
`endif
    bus.write_enable = 1'b0;
    step();
    chk_rd("collide_after", 16'h2222);

    // Different addresses in one edge
    bus.write_enable  = 1'b1;
    bus.address_write = 5'd8;
    bus.data_write    = 16'h0808;
    bus.address_read  = 5'd3;
    step();
    chk_rd("diff_addr_rd", 16'hA5A5);
    bus.write_enable = 1'b0;
    bus.address_read = 5'd8;
    step();
    chk_rd("diff_addr_wr", 16'h0808);

    // Back-to-back writes data=addr, then ordered reads
    for (int a = 0; a < 32; a++) begin
      bus.write_enable  = 1'b1;
      bus.address_write = 5'(a);
      bus.data_write    = 16'(a);
      step();
    end
    bus.write_enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.address_read = 5'(a);
      step();
      chk_rd("b2b_read", a);
    end

    // Extremes, then reset with a second reset at sweep edge 10
    bus.write_enable  = 1'b1;
    bus.address_write = 5'd0;
    bus.data_write    = 16'hFFFF;
    step();
    bus.address_write = 5'd31;
    bus.data_write    = 16'h8001;
    step();
    bus.write_enable = 1'b0;
    bus.address_read = 5'd0;
    step();
    chk_rd("pre_rst_addr0", 16'hFFFF);
    bus.address_read = 5'd31;
    step();
    chk_rd("pre_rst_addr31", 16'h8001);

    rst_n = 1'b0;
    step();
    chk_busy("rst3_busy", 1);
    chk_rd("rst3_rd", 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      chk_busy("abort_busy", 1);
    end
    rst_n = 1'b0;
    step();
    chk_busy("abort_rst_busy", 1);
    chk_rd("abort_rst_rd", 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_busy("reinit_busy", (e < 32) ? 1 : 0);
      chk_rd("reinit_rd_zero", 0);
    end
    bus.address_read = 5'd0;
    step();
    chk_rd("reinit_addr0", 16'h0000);
    bus.address_read = 5'd31;
    step();
    chk_rd("reinit_addr31", 16'h0000);
    bus.address_read = 5'd20;
    step();
    chk_rd("reinit_addr20", 16'h0000);
    chk_busy("stay_idle", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dut.md
DUT -- requirements
Module: dut

Interface
REQ-001 Parameter D_WIDTH, default 16, data word width in bits.
REQ-002 Parameter A_WIDTH, default 5, address width in bits; depth = 2**A_WIDTH words.
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 address_write  input  A_WIDTH  write address.
REQ-006 data_write  input  D_WIDTH  write data.
REQ-007 write_enable  input  1  write request, active-high.
REQ-008 address_read  input  A_WIDTH  read address.
REQ-009 data_read  output  D_WIDTH  registered read data.
REQ-010 init_busy  output  1  high while post-reset memory clear is in progress.

Function
REQ-011 Storage SHALL be 2**A_WIDTH words of D_WIDTH bits, addressed 0..2**A_WIDTH-1, no address wrap or aliasing.
REQ-012 Write: at a rising edge with write_enable=1 and init_busy=0, mem[address_write] SHALL take data_write.
REQ-013 Write requests while init_busy=1 SHALL be dropped, not queued.
REQ-014 Read: at every rising edge with init_busy=0, data_read SHALL take mem[address_read]; latency exactly 1 cycle, no read enable.
REQ-015 While init_busy=1, data_read SHALL be loaded with 0 each edge.
REQ-016 Same-address read and write in one edge, bypass disabled: data_read SHALL return the old (pre-write) word.
REQ-017 Different-address read and write in one edge SHALL both complete independently.
REQ-018 Init sequence: internal pointer clears one location per edge, starting at 0 and ascending.
REQ-019 First edge with rst_n=1 SHALL clear location 0; edge N (N=1..2**A_WIDTH) clears location N-1.
REQ-020 The edge clearing location 2**A_WIDTH-1 SHALL also drive init_busy to 0; writes are accepted from the next edge.
REQ-021 The init pointer SHALL NOT wrap or restart after completion, except on reset.

Reset
REQ-022 At a rising edge with rst_n=0: data_read<=0, init_busy<=1, init pointer<=0.
REQ-023 Memory contents SHALL NOT be altered during the reset edges themselves; they are cleared only by the init sequence.
REQ-024 Reset asserted mid-init or mid-operation SHALL abort the current activity and restart init from location 0 after release.
REQ-025 Memory is undefined only before the first reset; after init completes every word reads 0 until written.

Configuration
REQ-026 Macro DUT_BYPASS_EN: when defined, a same-address read and write in one edge (init_busy=0) SHALL return data_write on data_read.
REQ-027 Without DUT_BYPASS_EN, REQ-016 old-data behaviour applies; all other behaviour is identical in both builds.

Verification
REQ-028 Hold rst_n=0 2 edges, release -> init_busy=1 for exactly 32 edges, then 0; data_read=0 throughout.
REQ-029 After init, write 0xA5A5 to addr 3; next edge read addr 3 -> data_read=0xA5A5 one cycle later; read addr 4 -> 0x0000.
REQ-030 During init (edge 5 after release), write 0x1234 to addr 31; after init read addr 31 -> 0x0000.
REQ-031 Addr 7 holds 0x1111; same edge write 0x2222 to addr 7 and read addr 7 -> 0x1111 (default) or 0x2222 (DUT_BYPASS_EN); next read -> 0x2222.
REQ-032 Write 0xFFFF to addr 0 and 0x8001 to addr 31, then assert rst_n=0 at init edge 10 -> init restarts; after 32 edges both addrs read 0x0000.
REQ-033 Back-to-back writes addr 0..31 with data=addr, then reads 0..31 -> data_read returns 0..31 in order, one cycle delayed.
